// File: rtl/membus_arb.sv
// Round-robin arbiter granting one master at a time onto the ext-memory or GPIO target.
// Each grant covers one whole access (with per-target wait states) and ends in a one-cycle done pulse.
module membus_arb #(
    parameter int unsigned NMASTERS  = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned GPIO_BIT  = 9,
    parameter int unsigned WAIT_EXT  = 1,
    parameter int unsigned WAIT_GPIO = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NMASTERS-1:0]        request,
    input  logic [NMASTERS-1:0]        memread,
    input  logic [NMASTERS-1:0]        memwrite,
    input  logic [NMASTERS*ADDR_W-1:0] addr,
    input  logic [NMASTERS*DATA_W-1:0] writedata,
    output logic [NMASTERS-1:0]        grant,
    output logic [NMASTERS-1:0]        done,
    output logic [DATA_W-1:0]          readdata,
    input  logic [DATA_W-1:0]          readdata_ext,
    input  logic [DATA_W-1:0]          readdata_gpio,
    output logic                       memread_ext,
    output logic                       memwrite_ext,
    output logic [ADDR_W-1:0]          addr_ext,
    output logic [DATA_W-1:0]          writedata_ext,
    output logic                       memread_gpio,
    output logic                       memwrite_gpio,
    output logic [ADDR_W-1:0]          addr_gpio,
    output logic [DATA_W-1:0]          writedata_gpio
);

    localparam int unsigned MAX_WAIT = (WAIT_EXT > WAIT_GPIO) ? WAIT_EXT : WAIT_GPIO;
    localparam int unsigned CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned IDX_W    = $clog2(NMASTERS);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_last, rr_nxt;
    logic [IDX_W-1:0]   sel, sel_nxt;
    logic [IDX_W-1:0]   win, cand;
    logic               found;
    logic               tgt_q, tgt_nxt, rd_q, rd_nxt, wr_q, wr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NMASTERS-1:0] grant_nxt, done_nxt;
    logic [DATA_W-1:0]  readdata_nxt;
    logic               mr_ext_nxt, mw_ext_nxt, mr_gpio_nxt, mw_gpio_nxt;
    logic [ADDR_W-1:0]  a_ext_nxt, a_gpio_nxt;
    logic [DATA_W-1:0]  wd_ext_nxt, wd_gpio_nxt;

    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_gpio, w_rd, w_wr;

    // Round-robin pick: first requester after the last served master
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NMASTERS; i++) begin
            cand = IDX_W'((32'(rr_last) + i) % NMASTERS);
            if (!found && request[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign w_addr  = addr[32'(win) * ADDR_W +: ADDR_W];
    assign w_wdata = writedata[32'(win) * DATA_W +: DATA_W];
    assign w_gpio  = w_addr[GPIO_BIT];
    assign w_rd    = memread[win];
    assign w_wr    = memwrite[win];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|request) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and the latched transaction
    always_comb begin
        grant_nxt    = grant;
        done_nxt     = '0;
        readdata_nxt = readdata;
        cnt_nxt      = cnt;
        rr_nxt       = rr_last;
        sel_nxt      = sel;
        tgt_nxt      = tgt_q;
        rd_nxt       = rd_q;
        wr_nxt       = wr_q;
        mr_ext_nxt   = memread_ext;
        mw_ext_nxt   = memwrite_ext;
        a_ext_nxt    = addr_ext;
        wd_ext_nxt   = writedata_ext;
        mr_gpio_nxt  = memread_gpio;
        mw_gpio_nxt  = memwrite_gpio;
        a_gpio_nxt   = addr_gpio;
        wd_gpio_nxt  = writedata_gpio;
        case (state)
            IDLE: if (|request) begin
                sel_nxt     = win;
                tgt_nxt     = w_gpio;
                rd_nxt      = w_rd;
                wr_nxt      = w_wr;
                grant_nxt   = NMASTERS'(1) << win;
                cnt_nxt     = w_gpio ? CNT_W'(WAIT_GPIO) : CNT_W'(WAIT_EXT);
                // A simultaneous read+write is treated as a write only
                mr_ext_nxt  = !w_gpio && w_rd && !w_wr;
                mw_ext_nxt  = !w_gpio && w_wr;
                a_ext_nxt   = w_gpio ? '0 : w_addr;
                wd_ext_nxt  = w_gpio ? '0 : w_wdata;
                mr_gpio_nxt = w_gpio && w_rd && !w_wr;
                mw_gpio_nxt = w_gpio && w_wr;
                a_gpio_nxt  = w_gpio ? w_addr : '0;
                wd_gpio_nxt = w_gpio ? w_wdata : '0;
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    if (rd_q && !wr_q) readdata_nxt = tgt_q ? readdata_gpio : readdata_ext;
                    done_nxt    = grant;
                    grant_nxt   = '0;
                    mr_ext_nxt  = 1'b0;
                    mw_ext_nxt  = 1'b0;
                    a_ext_nxt   = '0;
                    wd_ext_nxt  = '0;
                    mr_gpio_nxt = 1'b0;
                    mw_gpio_nxt = 1'b0;
                    a_gpio_nxt  = '0;
                    wd_gpio_nxt = '0;
                end
            end
            DONE:    rr_nxt = sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant          <= '0;
            done           <= '0;
            readdata       <= '0;
            cnt            <= '0;
            rr_last        <= IDX_W'(NMASTERS - 1);
            sel            <= '0;
            tgt_q          <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            memread_ext    <= 1'b0;
            memwrite_ext   <= 1'b0;
            addr_ext       <= '0;
            writedata_ext  <= '0;
            memread_gpio   <= 1'b0;
            memwrite_gpio  <= 1'b0;
            addr_gpio      <= '0;
            writedata_gpio <= '0;
        end else begin
            grant          <= grant_nxt;
            done           <= done_nxt;
            readdata       <= readdata_nxt;
            cnt            <= cnt_nxt;
            rr_last        <= rr_nxt;
            sel            <= sel_nxt;
            tgt_q          <= tgt_nxt;
            rd_q           <= rd_nxt;
            wr_q           <= wr_nxt;
            memread_ext    <= mr_ext_nxt;
            memwrite_ext   <= mw_ext_nxt;
            addr_ext       <= a_ext_nxt;
            writedata_ext  <= wd_ext_nxt;
            memread_gpio   <= mr_gpio_nxt;
            memwrite_gpio  <= mw_gpio_nxt;
            addr_gpio      <= a_gpio_nxt;
            writedata_gpio <= wd_gpio_nxt;
        end
    end

endmodule

// File: tb/tb_membus_arb.sv
// Directed bench for membus_arb: a 2-master instance for reset, ext/GPIO access and ordering,
// and a 3-master instance for round-robin rotation.
module tb_membus_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 2-master instance
    logic [1:0]  request, memread, memwrite, grant, done;
    logic [31:0] addr;
    logic [15:0] writedata;
    logic [7:0]  readdata, readdata_ext, readdata_gpio, writedata_ext, writedata_gpio;
    logic        memread_ext, memwrite_ext, memread_gpio, memwrite_gpio;
    logic [15:0] addr_ext, addr_gpio;

    // 3-master instance
    logic [2:0]  t3_request, t3_memread, t3_memwrite, t3_grant, t3_done;
    logic [47:0] t3_addr;
    logic [23:0] t3_writedata;
    logic [7:0]  t3_readdata, t3_readdata_ext, t3_readdata_gpio, t3_writedata_ext, t3_writedata_gpio;
    logic        t3_memread_ext, t3_memwrite_ext, t3_memread_gpio, t3_memwrite_gpio;
    logic [15:0] t3_addr_ext, t3_addr_gpio;

    wire [25:0] ext2  = {memread_ext, memwrite_ext, addr_ext, writedata_ext};
    wire [25:0] gpio2 = {memread_gpio, memwrite_gpio, addr_gpio, writedata_gpio};
    wire [63:0] all2  = {grant, done, readdata, ext2, gpio2};
    wire [65:0] all3  = {t3_grant, t3_done, t3_readdata, t3_memread_ext, t3_memwrite_ext, t3_addr_ext,
                         t3_writedata_ext, t3_memread_gpio, t3_memwrite_gpio, t3_addr_gpio, t3_writedata_gpio};

    logic [2:0]  rr_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [15:0] rr_addr  [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0001};

    membus_arb #(.NMASTERS(2)) dut (
        .clk(clk), .reset(reset), .request(request), .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .grant(grant), .done(done), .readdata(readdata),
        .readdata_ext(readdata_ext), .readdata_gpio(readdata_gpio),
        .memread_ext(memread_ext), .memwrite_ext(memwrite_ext), .addr_ext(addr_ext),
        .writedata_ext(writedata_ext), .memread_gpio(memread_gpio), .memwrite_gpio(memwrite_gpio),
        .addr_gpio(addr_gpio), .writedata_gpio(writedata_gpio)
    );

    membus_arb #(.NMASTERS(3)) dut3 (
        .clk(clk), .reset(reset), .request(t3_request), .memread(t3_memread), .memwrite(t3_memwrite),
        .addr(t3_addr), .writedata(t3_writedata), .grant(t3_grant), .done(t3_done),
        .readdata(t3_readdata), .readdata_ext(t3_readdata_ext), .readdata_gpio(t3_readdata_gpio),
        .memread_ext(t3_memread_ext), .memwrite_ext(t3_memwrite_ext), .addr_ext(t3_addr_ext),
        .writedata_ext(t3_writedata_ext), .memread_gpio(t3_memread_gpio),
        .memwrite_gpio(t3_memwrite_gpio), .addr_gpio(t3_addr_gpio), .writedata_gpio(t3_writedata_gpio)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        request = '0; memread = '0; memwrite = '0; addr = '0; writedata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        readdata_ext = 8'h00; readdata_gpio = 8'h00;
        t3_request = '0; t3_memread = '0; t3_memwrite = '0; t3_addr = '0; t3_writedata = '0;
        t3_readdata_ext = 8'h00; t3_readdata_gpio = 8'h00;
        repeat (2) step();
        if (all2 !== 64'd0) begin failures++; $display("FAIL reset_outs2 got=%h exp=0", all2); end checks++;
        if (all3 !== 66'd0) begin failures++; $display("FAIL reset_outs3 got=%h exp=0", all3); end checks++;
        reset = 1'b0;
        request = 2'b10; memread = 2'b10; addr = {16'h0044, 16'h0000};
        step();
        if (grant !== 2'b10) begin failures++; $display("FAIL reset_pre_grant got=%b exp=10", grant); end checks++;
        if (memread_ext !== 1'b1) begin failures++; $display("FAIL reset_pre_strobe got=%b exp=1", memread_ext); end checks++;
        #2 reset = 1'b1;
        #1;
        if (all2 !== 64'd0) begin failures++; $display("FAIL reset_async got=%h exp=0", all2); end checks++;
        step(); step();
        reset = 1'b0;
        request = 2'b11; memread = 2'b11; addr = {16'h0044, 16'h0010};
        step();
        if (grant !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", grant); end checks++;
        if (addr_ext !== 16'h0010) begin failures++; $display("FAIL reset_first_addr got=%h exp=0010", addr_ext); end checks++;
        if (done !== 2'b00) begin failures++; $display("FAIL reset_no_done got=%b exp=00", done); end checks++;
        clear_inputs();
        step(); step();
        if (done !== 2'b01) begin failures++; $display("FAIL reset_first_done got=%b exp=01", done); end checks++;
        step();
    endtask

    task automatic test_single_ext_read();
        readdata_ext = 8'hA5;
        request = 2'b01; memread = 2'b01; addr = {16'h0000, 16'h0012};
        step();
        if (grant !== 2'b01) begin failures++; $display("FAIL rd_grant got=%b exp=01", grant); end checks++;
        if (memread_ext !== 1'b1) begin failures++; $display("FAIL rd_strobe_c1 got=%b exp=1", memread_ext); end checks++;
        if (addr_ext !== 16'h0012) begin failures++; $display("FAIL rd_addr got=%h exp=0012", addr_ext); end checks++;
        if (gpio2 !== 26'd0) begin failures++; $display("FAIL rd_gpio_idle got=%h exp=0", gpio2); end checks++;
        clear_inputs();
        step();
        if (memread_ext !== 1'b1) begin failures++; $display("FAIL rd_strobe_c2 got=%b exp=1", memread_ext); end checks++;
        if (done !== 2'b00) begin failures++; $display("FAIL rd_early_done got=%b exp=00", done); end checks++;
        step();
        if (done !== 2'b01) begin failures++; $display("FAIL rd_done got=%b exp=01", done); end checks++;
        if (readdata !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", readdata); end checks++;
        if ({grant, ext2} !== 28'd0) begin failures++; $display("FAIL rd_release got=%h exp=0", {grant, ext2}); end checks++;
        step();
        if (done !== 2'b00) begin failures++; $display("FAIL rd_done_width got=%b exp=00", done); end checks++;
    endtask

    task automatic test_gpio_write();
        request = 2'b10; memwrite = 2'b10; addr = {16'h0200, 16'h0000}; writedata = {8'h3C, 8'h00};
        step();
        if (grant !== 2'b10) begin failures++; $display("FAIL wr_grant got=%b exp=10", grant); end checks++;
        if (gpio2 !== {1'b0, 1'b1, 16'h0200, 8'h3C}) begin failures++; $display("FAIL wr_gpio got=%h exp=%h", gpio2, {1'b0, 1'b1, 16'h0200, 8'h3C}); end checks++;
        if (ext2 !== 26'd0) begin failures++; $display("FAIL wr_ext_idle got=%h exp=0", ext2); end checks++;
        clear_inputs();
        step();
        if (done !== 2'b10) begin failures++; $display("FAIL wr_done got=%b exp=10", done); end checks++;
        if (memwrite_gpio !== 1'b0) begin failures++; $display("FAIL wr_strobe_len got=%b exp=0", memwrite_gpio); end checks++;
        if (readdata !== 8'hA5) begin failures++; $display("FAIL wr_readdata got=%h exp=a5", readdata); end checks++;
        step();
    endtask

    task automatic test_drop_in_access();
        readdata_ext = 8'h5A; readdata_gpio = 8'hC3;
        request = 2'b11; memread = 2'b11; addr = {16'h0200, 16'h0034};
        step();
        if (grant !== 2'b01) begin failures++; $display("FAIL drop_grant0 got=%b exp=01", grant); end checks++;
        if (addr_ext !== 16'h0034) begin failures++; $display("FAIL drop_addr0 got=%h exp=0034", addr_ext); end checks++;
        request = 2'b10;
        step();
        if (grant !== 2'b01) begin failures++; $display("FAIL drop_hold got=%b exp=01", grant); end checks++;
        step();
        if (done !== 2'b01) begin failures++; $display("FAIL drop_done0 got=%b exp=01", done); end checks++;
        if (readdata !== 8'h5A) begin failures++; $display("FAIL drop_data0 got=%h exp=5a", readdata); end checks++;
        step();
        if ({grant, done} !== 4'b0000) begin failures++; $display("FAIL drop_idle got=%b exp=0000", {grant, done}); end checks++;
        step();
        if (grant !== 2'b10) begin failures++; $display("FAIL drop_grant1 got=%b exp=10", grant); end checks++;
        if ({memread_gpio, addr_gpio} !== {1'b1, 16'h0200}) begin failures++; $display("FAIL drop_gpio1 got=%h exp=%h", {memread_gpio, addr_gpio}, {1'b1, 16'h0200}); end checks++;
        clear_inputs();
        step();
        if (done !== 2'b10) begin failures++; $display("FAIL drop_done1 got=%b exp=10", done); end checks++;
        if (readdata !== 8'hC3) begin failures++; $display("FAIL drop_data1 got=%h exp=c3", readdata); end checks++;
        step();
    endtask

    task automatic test_rw_conflict();
        readdata_ext = 8'h77;
        request = 2'b01; memread = 2'b01; memwrite = 2'b01; addr = {16'h0000, 16'h0005}; writedata = {8'h00, 8'h9E};
        step();
        if (ext2 !== {1'b0, 1'b1, 16'h0005, 8'h9E}) begin failures++; $display("FAIL rw_ext got=%h exp=%h", ext2, {1'b0, 1'b1, 16'h0005, 8'h9E}); end checks++;
        clear_inputs();
        step();
        if ({memread_ext, memwrite_ext} !== 2'b01) begin failures++; $display("FAIL rw_strobe_c2 got=%b exp=01", {memread_ext, memwrite_ext}); end checks++;
        step();
        if (done !== 2'b01) begin failures++; $display("FAIL rw_done got=%b exp=01", done); end checks++;
        if (readdata !== 8'hC3) begin failures++; $display("FAIL rw_readdata got=%h exp=c3", readdata); end checks++;
        step();
    endtask

    task automatic test_round_robin();
        t3_request = 3'b111; t3_memread = 3'b111; t3_addr = {16'h0003, 16'h0002, 16'h0001};
        for (int t = 0; t < 4; t++) begin
            step();
            if (t3_grant !== rr_grant[t]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", t, t3_grant, rr_grant[t]); end checks++;
            if (t3_addr_ext !== rr_addr[t]) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", t, t3_addr_ext, rr_addr[t]); end checks++;
            step();
            step();
            if ({t3_grant, t3_done} !== {3'b000, rr_grant[t]}) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=%b", t, {t3_grant, t3_done}, {3'b000, rr_grant[t]}); end checks++;
            step();
            if ({t3_grant, t3_done} !== 6'b0) begin failures++; $display("FAIL rr_gap[%0d] got=%b exp=000000", t, {t3_grant, t3_done}); end checks++;
        end
        t3_request = '0; t3_memread = '0;
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_single_ext_read();
        test_gpio_write();
        test_drop_in_access();
        test_rw_conflict();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
